// File: rtl/shift_sequencer_if.sv
// Request/response and shared-ALU signal bundle for shift_sequencer.
// master: requester plus external ALU; slave: the sequencer itself.
interface shift_sequencer_if;
    logic        start;
    logic [1:0]  funct;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_in0;
    logic [31:0] alu_in1;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;

    modport master (
        output start, funct, operand, shamt, alu_out,
        input  busy, done, result, alu_in0, alu_in1, alu_op
    );

    modport slave (
        input  start, funct, operand, shamt, alu_out,
        output busy, done, result, alu_in0, alu_in1, alu_op
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter that reuses a shared one-bit-per-op ALU (SLL/SRL/SRA).
// Optional macro SHIFT_SEQ_ABORT_EN adds an abort input honoured in SHIFT.
module shift_sequencer (
    input  logic clk,
    input  logic rst_n,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic abort,
`endif
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0100;
    localparam logic [1:0] K_SLL  = 2'b00;
    localparam logic [1:0] K_SRL  = 2'b01;
    localparam logic [1:0] K_SRA  = 2'b10;
    localparam logic [1:0] K_RSV  = 2'b11;

    state_t      state, state_nxt;
    logic [31:0] acc;
    logic [31:0] result_q;
    logic [4:0]  cnt;
    logic [1:0]  kind;
    logic        accept;
    logic        abort_hit;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        bus.alu_op = OP_ADD;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    // Zero shifts and the reserved kind skip SHIFT, so cnt never wraps.
                    if (bus.shamt == '0 || bus.funct == K_RSV) state_nxt = DONE;
                    else                                       state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                case (kind)
                    K_SLL:   bus.alu_op = OP_SLL;
                    K_SRL:   bus.alu_op = OP_SRL;
                    K_SRA:   bus.alu_op = OP_SRA;
                    default: bus.alu_op = OP_ADD;
                endcase
                if (abort_hit)         state_nxt = IDLE;
                else if (cnt == 5'd1)  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            kind     <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                acc  <= bus.operand;
                cnt  <= bus.shamt;
                kind <= bus.funct;
            end else if (state == SHIFT && !abort_hit) begin
                acc <= bus.alu_out;
                cnt <= cnt - 5'd1;
            end
            if (state == DONE) result_q <= acc;
        end
    end

    // result shows acc live during DONE, then the captured copy until the next DONE.
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.result  = (state == DONE) ? acc : result_q;
    assign bus.alu_in0 = acc;
    assign bus.alu_in1 = '0;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed plus randomized bench for shift_sequencer with a behavioural ALU and
// a whole-shift reference model; exercises abort when SHIFT_SEQ_ABORT_EN is set.
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic rst_n;
`ifdef SHIFT_SEQ_ABORT_EN
    logic abort;
`endif
    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] last_exp = '0;

    shift_sequencer_if bus ();

    shift_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External ALU: one-bit shifts or add, as the shared datapath would provide.
    always_comb begin
        case (bus.alu_op)
            4'b0111: bus.alu_out = bus.alu_in0 << 1;
            4'b0110: bus.alu_out = bus.alu_in0 >> 1;
            4'b0100: bus.alu_out = $unsigned($signed(bus.alu_in0) >>> 1);
            4'b0010: bus.alu_out = bus.alu_in0 + bus.alu_in1;
            default: bus.alu_out = 32'hBAD0_BAD0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] v,
                                               input logic [4:0] sa);
        case (f)
            2'b00:   return v << sa;
            2'b01:   return v >> sa;
            2'b10:   return $unsigned($signed(v) >>> sa);
            default: return v;
        endcase
    endfunction

    function automatic logic [3:0] ref_op(input logic [1:0] f);
        case (f)
            2'b00:   return 4'b0111;
            2'b01:   return 4'b0110;
            2'b10:   return 4'b0100;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic run_op(input logic [1:0] f, input logic [31:0] v, input logic [4:0] sa,
                          input string tag);
        logic [31:0] exp_res;
        int exp_lat, exp_shifts, lat, n_match, n_any;
        bit busy_ok;
        exp_res    = ref_result(f, v, sa);
        exp_lat    = (f == 2'b11 || sa == 0) ? 1 : int'(sa) + 1;
        exp_shifts = (f == 2'b11) ? 0 : int'(sa);
        lat = 0; n_match = 0; n_any = 0; busy_ok = 1'b1;
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        bus.start = 1'b1; bus.funct = f; bus.operand = v; bus.shamt = sa;
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.alu_op == ref_op(f)) n_match++;
            if (bus.alu_op inside {4'b0111, 4'b0110, 4'b0100}) n_any++;
            // Stray requests with fresh operands while busy must be ignored.
            bus.start   = 1'($urandom_range(0, 1));
            bus.funct   = 2'($urandom);
            bus.operand = $urandom;
            bus.shamt   = 5'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_done_op"}, 32'(bus.alu_op), 32'h2);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_nshift"}, 32'(n_any), 32'(exp_shifts));
        if (f != 2'b11) check({tag, "_opmatch"}, 32'(n_match), 32'(exp_shifts));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_hold"}, bus.result, exp_res);
        last_exp = exp_res;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.funct = '0; bus.operand = '0; bus.shamt = '0;
`ifdef SHIFT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_in0", bus.alu_in0, 32'd0);
        check("rst_in1", bus.alu_in1, 32'd0);
        check("rst_op", 32'(bus.alu_op), 32'h2);
        rst_n = 1'b1;

        run_op(2'b00, 32'h0000_0001, 5'd4, "sll1x4");
        run_op(2'b10, 32'h8000_0000, 5'd31, "sra31");
        run_op(2'b01, 32'h8000_0000, 5'd31, "srl31");
        run_op(2'b01, 32'hDEAD_BEEF, 5'd0, "srl0");
        run_op(2'b00, 32'h0000_0003, 5'd2, "sll3x2");
        run_op(2'b11, 32'h1234_5678, 5'd9, "rsv");
        run_op(2'b10, 32'h7FFF_FFF0, 5'd1, "sra_pos");

        // Reset lands in the third SHIFT cycle of SLL 0x1 by 8.
        bus.start = 1'b1; bus.funct = 2'b00; bus.operand = 32'h1; bus.shamt = 5'd8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        check("mid_done", 32'(bus.done), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abrst_busy", 32'(bus.busy), 32'd0);
        check("abrst_done", 32'(bus.done), 32'd0);
        check("abrst_result", bus.result, 32'd0);
        check("abrst_in0", bus.alu_in0, 32'd0);
        rst_n = 1'b1;
        run_op(2'b01, 32'h0000_0100, 5'd4, "post_rst");

`ifdef SHIFT_SEQ_ABORT_EN
        bus.start = 1'b1; bus.funct = 2'b00; bus.operand = 32'h5; bus.shamt = 5'd6;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", bus.result, last_exp);
        run_op(2'b00, 32'h0000_0005, 5'd3, "post_abort");
`endif

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), $urandom, 5'($urandom), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n, sampled on the rising edge of clk.
REQ-002 Port clk: input, 1 bit, rising-edge clock.
REQ-003 Port rst_n: input, 1 bit, synchronous active-low reset.
REQ-004 Port start: input, 1 bit, request a shift; sampled only in IDLE.
REQ-005 Port funct: input, 2 bits, shift kind: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-006 Port operand: input, 32 bits, value to shift; captured when start is accepted.
REQ-007 Port shamt: input, 5 bits, shift amount 0..31; captured when start is accepted.
REQ-008 Port busy: output, 1 bit, high in any state other than IDLE.
REQ-009 Port done: output, 1 bit, single-cycle completion pulse.
REQ-010 Port result: output, 32 bits, shifted value; valid while done is high and held until the next done.
REQ-011 Port alu_in0: output, 32 bits, drives the shared ALU in0; always equals the internal accumulator.
REQ-012 Port alu_in1: output, 32 bits, drives the ALU in1; constant 0.
REQ-013 Port alu_op: output, 4 bits, ALU opcode.
REQ-014 Port alu_out: input, 32 bits, ALU result, combinational from alu_in0 and alu_op.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE with start=1, the block SHALL load acc<=operand, cnt<=shamt and kind<=funct.
REQ-017 On acceptance, the next state SHALL be DONE if shamt==0 or funct==11, otherwise SHIFT.
REQ-018 In IDLE with start=0, the block SHALL remain in IDLE and keep acc unchanged.
REQ-019 In SHIFT, each clock SHALL do acc<=alu_out and cnt<=cnt-1; when cnt==1 the next state SHALL be DONE.
REQ-020 In SHIFT, alu_op SHALL be 0111 for SLL, 0110 for SRL and 0100 for SRA; the ALU shifts by one bit per operation.
REQ-021 In IDLE and DONE, alu_op SHALL be 0010 (add); the ALU output is ignored in these states.
REQ-022 In DONE, done SHALL be 1 and result SHALL be acc; the next state SHALL unconditionally be IDLE.
REQ-023 Latency: done SHALL be high in the cycle exactly shamt+1 cycles after the cycle in which start was sampled high; reserved funct SHALL give a latency of 1.
REQ-024 Reserved funct 11 SHALL return result=operand unchanged and SHALL NOT drive any shift opcode.
REQ-025 start SHALL be ignored while busy=1, including in DONE; a new start is accepted no earlier than the cycle after done.
REQ-026 Changes to operand, shamt or funct after acceptance SHALL NOT affect the operation in flight.
REQ-027 cnt SHALL never wrap: the SHIFT state is entered only with cnt>=1.
REQ-028 SRA SHALL replicate operand[31] into the vacated bits, so SRA 0x80000000 by 31 gives 0xFFFFFFFF.

Reset
REQ-029 With rst_n=0 at a rising edge, the block SHALL enter IDLE and set acc=0, cnt=0, kind=00, result=0, done=0 and busy=0.
REQ-030 Reset SHALL take priority over start and abort, and mid-operation SHALL discard the operation without a done pulse.
REQ-031 In the cycle after reset is released, the block SHALL be able to accept a start.

Configuration
REQ-032 Macro SHIFT_SEQ_ABORT_EN SHALL, when defined, add input port abort (1 bit).
REQ-033 With SHIFT_SEQ_ABORT_EN, abort=1 in SHIFT SHALL force IDLE on the next edge, with no done and result unchanged; abort SHALL be ignored in IDLE and DONE.
REQ-034 Without SHIFT_SEQ_ABORT_EN, the abort port SHALL NOT exist and the behaviour SHALL be identical to the abort=0 case.

Verification
REQ-035 Scenario: SLL, operand=0x00000001, shamt=4 -> done 5 cycles after start, result=0x00000010, alu_op=0111 for exactly 4 cycles.
REQ-036 Scenario: SRA, operand=0x80000000, shamt=31 -> done 32 cycles after start, result=0xFFFFFFFF; SRL with the same inputs -> result=0x00000001.
REQ-037 Scenario: SRL, shamt=0, operand=0xDEADBEEF -> done 1 cycle after start, result=0xDEADBEEF, alu_op never 0110.
REQ-038 Scenario: a second start with different operands while busy (SLL 0x3 by 2 in flight) -> ignored, result=0x0000000C, and a start in the cycle after done is accepted.
REQ-039 Scenario: rst_n=0 at the 3rd SHIFT cycle of SLL 0x1 by 8 -> busy=0, result=0, no done pulse; a new SRL 0x100 by 4 then gives 0x10.
REQ-040 Scenario (SHIFT_SEQ_ABORT_EN defined): abort at the 2nd SHIFT cycle -> IDLE on the next edge, done stays 0, result keeps its previous value.
